rf_scoreboard: RTL

// - Parametrised successor to the 8x16b register file: DEPTH x WIDTH storage, two

---
 rtl/rf_pkg.sv | 14 +
 rtl/rf_busy_tracker.sv | 63 ++++++
 rtl/rf_scoreboard.sv | 93 +++++++++
 3 files changed

// File: rtl/rf_pkg.sv
// rf_pkg: shared defaults, selector sizing helper and selector type
// for the scoreboarded register file (optional forwarding: RF_BYPASS_EN).
package rf_pkg;

    localparam int RF_WIDTH_DEF = 16;
    localparam int RF_DEPTH_DEF = 8;

    function automatic int sel_width(input int depth);
        return $clog2(depth);
    endfunction

    typedef logic [sel_width(RF_DEPTH_DEF)-1:0] rf_sel_t;

endpackage

// File: rtl/rf_busy_tracker.sv
// rf_busy_tracker: per-register pending-producer bits plus the sticky
// orphan-writeback flag; issue wins over writeback on the same register.
module rf_busy_tracker
    import rf_pkg::*;
#(
    parameter int DEPTH    = RF_DEPTH_DEF,
    parameter int SELW     = sel_width(DEPTH),
    parameter int ZERO_REG = 0
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            issueEn,
    input  logic [SELW-1:0] issueRegSel,
    input  logic            writeEn,
    input  logic [SELW-1:0] writeRegSel,
    input  logic [SELW-1:0] read1RegSel,
    input  logic [SELW-1:0] read2RegSel,
    output logic            read1Busy,
    output logic            read2Busy,
    output logic            errOrphan
);

    logic [DEPTH-1:0] r_busy;
    logic             r_err;
    logic [DEPTH-1:0] w_busy_nxt;
    logic             w_iss_ok;
    logic             w_wr_ok;
    logic             w_orphan;

    // Register 0 is hardwired when ZERO_REG is set, so its events are dropped
    assign w_iss_ok = issueEn && !((ZERO_REG != 0) && (issueRegSel == '0));
    assign w_wr_ok  = writeEn && !((ZERO_REG != 0) && (writeRegSel == '0));
    assign w_orphan = w_wr_ok && !r_busy[writeRegSel];

    // Clear for writeback first, then set for issue so a new producer wins
    always_comb begin
        w_busy_nxt = r_busy;
        if (w_wr_ok) begin
            w_busy_nxt[writeRegSel] = 1'b0;
        end
        if (w_iss_ok) begin
            w_busy_nxt[issueRegSel] = 1'b1;
        end
    end

    // Busy bits and sticky orphan flag, both discarded by reset
    always_ff @(posedge clk) begin
        if (rst) begin
            r_busy <= '0;
            r_err  <= 1'b0;
        end else begin
            r_busy <= w_busy_nxt;
            if (w_orphan) begin
                r_err <= 1'b1;
            end
        end
    end

    assign read1Busy = r_busy[read1RegSel];
    assign read2Busy = r_busy[read2RegSel];
    assign errOrphan = r_err;

endmodule

// File: rtl/rf_scoreboard.sv
// rf_scoreboard: DEPTH x WIDTH register file, two async read ports, one
// sync write port, RAW busy scoreboard; RF_BYPASS_EN enables write forwarding.
module rf_scoreboard
    import rf_pkg::*;
#(
    parameter int WIDTH    = RF_WIDTH_DEF,
    parameter int DEPTH    = RF_DEPTH_DEF,
    parameter int SELW     = sel_width(DEPTH),
    parameter int ZERO_REG = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [SELW-1:0]  read1RegSel,
    input  logic [SELW-1:0]  read2RegSel,
    output logic [WIDTH-1:0] read1Data,
    output logic [WIDTH-1:0] read2Data,
    output logic             read1Busy,
    output logic             read2Busy,
    input  logic [SELW-1:0]  writeRegSel,
    input  logic [WIDTH-1:0] writeData,
    input  logic             writeEn,
    input  logic [SELW-1:0]  issueRegSel,
    input  logic             issueEn,
    output logic             errOrphan
);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic             w_wr_ok;
    logic             w_busy1;
    logic             w_busy2;
    logic             w_zero1;
    logic             w_zero2;

    assign w_wr_ok = writeEn && !((ZERO_REG != 0) && (writeRegSel == '0));
    assign w_zero1 = (ZERO_REG != 0) && (read1RegSel == '0);
    assign w_zero2 = (ZERO_REG != 0) && (read2RegSel == '0);

    rf_busy_tracker #(
        .DEPTH    (DEPTH),
        .SELW     (SELW),
        .ZERO_REG (ZERO_REG)
    ) u_busy (
        .clk         (clk),
        .rst         (rst),
        .issueEn     (issueEn),
        .issueRegSel (issueRegSel),
        .writeEn     (writeEn),
        .writeRegSel (writeRegSel),
        .read1RegSel (read1RegSel),
        .read2RegSel (read2RegSel),
        .read1Busy   (w_busy1),
        .read2Busy   (w_busy2),
        .errOrphan   (errOrphan)
    );

    // Data array: synchronous clear on reset, single write port
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else if (w_wr_ok) begin
            r_mem[writeRegSel] <= writeData;
        end
    end

    // Read muxes with optional same-cycle forwarding; reg 0 forced last
    always_comb begin
        read1Data = r_mem[read1RegSel];
        read1Busy = w_busy1;
        read2Data = r_mem[read2RegSel];
        read2Busy = w_busy2;
`ifdef RF_BYPASS_EN
        if (writeEn && (writeRegSel == read1RegSel)) begin
            read1Data = writeData;
            read1Busy = 1'b0;
        end
        if (writeEn && (writeRegSel == read2RegSel)) begin
            read2Data = writeData;
            read2Busy = 1'b0;
        end
`endif
        if (w_zero1) begin
            read1Data = '0;
            read1Busy = 1'b0;
        end
        if (w_zero2) begin
            read2Data = '0;
            read2Busy = 1'b0;
        end
    end

endmodule
